step_tick_gen: RTL and testbench

- Timebase and single-step front end for the seven-segment sequencer, which advances one state per enabled clock edge.
- Generates a one-cycle `tick` enable from the 50 MHz board clock in two modes:
  - free-running at a divided rate (RUN);
  - one tick per debounced pushbutton press (PAUSE).
- Also provides a 50% `slow_clk` for LED/scope observation.

---
 rtl/board_pkg.sv | 19 +
 rtl/btn_debounce.sv | 55 +++++
 rtl/step_tick_gen.sv | 104 ++++++++++
 tb/tb_step_tick_gen.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Board-level constants shared by the timebase and button front-end blocks.
package board_pkg;

    // Mode FSM encoding
    localparam logic ST_PAUSE = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    typedef logic mode_t;

    // Board clock and button settle time
    localparam int CLK_HZ = 50_000_000;
    localparam int DEB_MS = 20;

    // Debounce window in clk cycles for a given settle time
    function automatic int deb_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton front end: 2-flop synchroniser, stability counter, and a
// one-cycle press pulse on an accepted 1->0 level change (active-low button).
module btn_debounce
    import board_pkg::*;
#(
    parameter int DEB_COUNT = 1_000_000,
    parameter int DEB_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_COUNT - 1);

    logic             meta;
    logic             sync;
    logic [DEB_W-1:0] cnt;

    // Synchroniser; idle (released) level is 1, so flops reset high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= btn_n;
            sync <= meta;
        end
    end

    // Accept a new level only after DEB_COUNT consecutive mismatching cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync != level) begin
                if (cnt == DEB_LAST) begin
                    level <= sync;
                    cnt   <= '0;
                    press <= ~sync;
                end else begin
                    cnt <= cnt + DEB_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/step_tick_gen.sv
// Tick generator for the seven-segment sequencer: free-running divided tick
// in RUN, one tick per debounced button press in PAUSE, plus a 50% slow_clk.
module step_tick_gen
    import board_pkg::*;
#(
    parameter int DIV_COUNT = CLK_HZ,
    parameter int CNT_W     = 26,
    parameter int DEB_COUNT = deb_cycles(DEB_MS),
    parameter int DEB_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic run_sw,
    input  logic step_n,
    output logic tick,
    output logic slow_clk,
    output logic running,
    output logic btn_level
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_COUNT - 1);
    localparam logic [CNT_W-1:0] DIV_HALF = CNT_W'(DIV_COUNT / 2);

    logic             run_meta;
    logic             run_sync;
    mode_t            state;
    mode_t            state_nxt;
    logic [CNT_W-1:0] div_cnt;
    logic             press;

    btn_debounce #(
        .DEB_COUNT (DEB_COUNT),
        .DEB_W     (DEB_W)
    ) u_step_btn (
        .clk   (clk),
        .rst   (rst),
        .btn_n (step_n),
        .level (btn_level),
        .press (press)
    );

    // run_sw synchroniser; only run_sync feeds logic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_meta <= 1'b0;
            run_sync <= 1'b0;
        end else begin
            run_meta <= run_sw;
            run_sync <= run_meta;
        end
    end

    // Mode state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_PAUSE;
        else     state <= state_nxt;
    end

    // Mode follows the synchronised switch
    always_comb begin
        state_nxt = state;
        case (state)
            ST_PAUSE: if (run_sync)  state_nxt = ST_RUN;
            ST_RUN:   if (!run_sync) state_nxt = ST_PAUSE;
            default:  state_nxt = ST_PAUSE;
        endcase
    end

    // Mode outputs
    always_comb begin
        running = (state == ST_RUN);
    end

    // Divider: counts only while staying in RUN, so it enters RUN at 0 and
    // is back at 0 the first PAUSE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (state == ST_RUN && state_nxt == ST_RUN) begin
            if (div_cnt == DIV_LAST) div_cnt <= '0;
            else                     div_cnt <= div_cnt + CNT_W'(1);
        end else begin
            div_cnt <= '0;
        end
    end

    // Tick on divider wrap in RUN (including the exit cycle), or on a press in
    // PAUSE unless the switch is already asking for RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= 1'b0;
        end else begin
            tick <= ((state == ST_RUN) && (div_cnt == DIV_LAST)) ||
                    ((state == ST_PAUSE) && press && !run_sync);
        end
    end

    // Observation clock: high for the first half of each RUN period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) slow_clk <= 1'b0;
        else     slow_clk <= (state == ST_RUN) && (div_cnt < DIV_HALF);
    end

endmodule

// File: tb/tb_step_tick_gen.sv
// Directed bench for step_tick_gen with DIV_COUNT=10, DEB_COUNT=4.
module tb_step_tick_gen;

    logic clk = 1'b0;
    logic rst;
    logic run_sw;
    logic step_n;
    logic tick;
    logic slow_clk;
    logic running;
    logic btn_level;

    int n_checks = 0;
    int n_fail   = 0;
    int ticks;

    step_tick_gen #(
        .DIV_COUNT (10),
        .CNT_W     (4),
        .DEB_COUNT (4),
        .DEB_W     (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run_sw    (run_sw),
        .step_n    (step_n),
        .tick      (tick),
        .slow_clk  (slow_clk),
        .running   (running),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic count_ticks(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            cycle(1);
            if (tick) cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        run_sw = 1'b1;
        step_n = 1'b1;
        cycle(2);
        chk("rst_tick", tick, 1'b0);
        chk("rst_slow", slow_clk, 1'b0);
        chk("rst_running", running, 1'b0);
        chk("rst_btn", btn_level, 1'b1);

        // Release reset with RUN selected: running after 3 edges
        rst = 1'b0;
        cycle(2);
        chk("run_lat_early", running, 1'b0);
        cycle(1);
        chk("run_lat", running, 1'b1);

        // Tick every 10, slow_clk high 5 / low 5, tick on last low cycle
        for (int i = 1; i <= 30; i++) begin
            cycle(1);
            chk("run_tick", tick, (i % 10) == 0);
            chk("run_slow", slow_clk, ((i % 10) >= 1) && ((i % 10) <= 5));
        end

        // Async reset mid-run, tick currently high
        rst = 1'b1;
        #2;
        chk("async_tick", tick, 1'b0);
        chk("async_slow", slow_clk, 1'b0);
        chk("async_running", running, 1'b0);
        chk("async_btn", btn_level, 1'b1);
        run_sw = 1'b0;
        cycle(2);
        rst = 1'b0;
        cycle(2);

        // Clean press in PAUSE: level falls 6 edges after, tick one later
        step_n = 1'b0;
        cycle(5);
        chk("press_btn_early", btn_level, 1'b1);
        cycle(1);
        chk("press_btn_fall", btn_level, 1'b0);
        chk("press_tick_early", tick, 1'b0);
        step_n = 1'b1;
        cycle(1);
        chk("press_tick", tick, 1'b1);
        cycle(1);
        chk("press_tick_once", tick, 1'b0);
        count_ticks(12, ticks);
        chk_int("release_ticks", ticks, 0);
        chk("release_btn", btn_level, 1'b1);

        // Bounce: toggle every 2 cycles, then settle low
        for (int i = 0; i < 20; i++) begin
            step_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            cycle(2);
            chk("bounce_btn", btn_level, 1'b1);
        end
        chk("bounce_no_tick", tick, 1'b0);
        step_n = 1'b0;
        count_ticks(12, ticks);
        chk_int("bounce_settle_ticks", ticks, 1);
        chk("bounce_btn_low", btn_level, 1'b0);
        step_n = 1'b1;
        count_ticks(10, ticks);
        chk_int("bounce_release_ticks", ticks, 0);

        // Press while running is ignored, spacing kept
        run_sw = 1'b1;
        cycle(2);
        chk("run2_lat_early", running, 1'b0);
        cycle(1);
        chk("run2_lat", running, 1'b1);
        for (int i = 1; i <= 40; i++) begin
            if (i == 5)  step_n = 1'b0;
            if (i == 13) step_n = 1'b1;
            cycle(1);
            chk("run_press_tick", tick, (i % 10) == 0);
        end

        // Leave RUN so run_sync falls while div_cnt = 9
        cycle(7);
        run_sw = 1'b0;
        cycle(2);
        chk("wrap_pre_running", running, 1'b1);
        chk("wrap_pre_tick", tick, 1'b0);
        cycle(1);
        chk("wrap_tick", tick, 1'b1);
        chk("wrap_running", running, 1'b0);
        chk("wrap_slow", slow_clk, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1);
            chk("pause_tick", tick, 1'b0);
            chk("pause_slow", slow_clk, 1'b0);
        end

        // Press accepted on the cycle run_sync rises is dropped
        step_n = 1'b0;
        cycle(4);
        run_sw = 1'b1;
        cycle(2);
        chk("drop_btn", btn_level, 1'b0);
        chk("drop_running_early", running, 1'b0);
        chk("drop_tick_early", tick, 1'b0);
        cycle(1);
        chk("drop_tick", tick, 1'b0);
        chk("drop_running", running, 1'b1);
        for (int j = 1; j <= 10; j++) begin
            cycle(1);
            chk("drop_first_run_tick", tick, j == 10);
        end

        step_n = 1'b1;
        cycle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
